// File: rtl/cla_pkg.sv
// Shared carry-look-ahead types and helpers for the ALU adder and the branch comparator.
package cla_pkg;

    localparam int MAX_LA = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic p;
        logic g;
    } group_pg_t;

    // Carry out of the low n bits of a propagate/generate vector; bits at and above n are ignored.
    function automatic logic cla_cout(input logic [MAX_LA-1:0] p,
                                      input logic [MAX_LA-1:0] g,
                                      input logic              cin,
                                      input int                n);
        logic c;
        c = cin;
        for (int i = 0; i < MAX_LA; i++) begin
            if (i < n) begin
                c = g[i] | (p[i] & c);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit look-ahead group: in-group carries and sum from p/g and the group carry-in,
// plus the group propagate/generate terms for the second-level carry network.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             grp_p,
    output logic             grp_g
);

    logic [GROUP-1:0]  c_s;
    logic [MAX_LA-1:0] p_ext_s;
    logic [MAX_LA-1:0] g_ext_s;

    // In-group carries, sum bits and group P/G.
    always_comb begin
        c_s[0] = cin;
        for (int i = 0; i < GROUP - 1; i++) begin
            c_s[i+1] = g[i] | (p[i] & c_s[i]);
        end
        sum     = p ^ c_s;
        p_ext_s = '0;
        g_ext_s = '0;
        p_ext_s[GROUP-1:0] = p;
        g_ext_s[GROUP-1:0] = g;
        grp_p = &p;
        grp_g = cla_cout(p_ext_s, g_ext_s, 1'b0, GROUP);
    end

endmodule

// File: rtl/cla_pipelined_adder.sv
// Two-stage pipelined carry-look-ahead add/subtract unit with valid/ready on both sides.
// Stage 1 registers bit and group P/G terms; stage 2 resolves carries and registers sum and flags.
module cla_pipelined_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NG = WIDTH / GROUP;

    generate
        if ((WIDTH % GROUP) != 0) begin : g_bad_width
            $error("cla_pipelined_adder: WIDTH must be a multiple of GROUP");
        end
        if ((GROUP < 2) || (GROUP > MAX_LA)) begin : g_bad_group
            $error("cla_pipelined_adder: GROUP must be in 2..8");
        end
    endgenerate

    op_e                  op_s;
    logic [WIDTH-1:0]     bp_s;
    logic                 c0_s;
    logic [WIDTH-1:0]     p_s;
    logic [WIDTH-1:0]     g_s;
    group_pg_t [NG-1:0]   grp_s;

    logic                 s1_valid_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     bp_r;
    logic                 c0_r;
    logic [WIDTH-1:0]     p_r;
    logic [WIDTH-1:0]     g_r;
    group_pg_t [NG-1:0]   grp_r;

    logic [NG:0]          gc_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;
    logic                 ovf_s;
    logic                 zero_s;
    logic [NG-1:0]        unused_grp_p_s;
    logic [NG-1:0]        unused_grp_g_s;

    logic                 advance_s;
    logic                 in_ready_s;
    logic                 accept_s;

    logic                 out_valid_r;
    logic [WIDTH-1:0]     out_sum_r;
    logic                 out_cout_r;
    logic                 out_ovf_r;
    logic                 out_zero_r;

    // Handshake: stage 2 drains when the output slot is free or being consumed.
    always_comb begin
        advance_s  = s1_valid_r & (~out_valid_r | out_ready);
        in_ready_s = ~s1_valid_r | advance_s;
        accept_s   = in_valid & in_ready_s;
    end

    // Stage-1 operand conditioning, bit terms and first-level group P/G.
    always_comb begin
        logic [MAX_LA-1:0] pe;
        logic [MAX_LA-1:0] ge;
        op_s = op_e'(in_sub);
        if (op_s == OP_SUB) begin
            bp_s = ~in_b;
            c0_s = 1'b1;
        end else begin
            bp_s = in_b;
            c0_s = in_cin;
        end
        p_s = in_a ^ bp_s;
        g_s = in_a & bp_s;
        for (int k = 0; k < NG; k++) begin
            pe = '0;
            ge = '0;
            pe[GROUP-1:0] = p_s[k*GROUP +: GROUP];
            ge[GROUP-1:0] = g_s[k*GROUP +: GROUP];
            grp_s[k].p = &p_s[k*GROUP +: GROUP];
            grp_s[k].g = cla_cout(pe, ge, 1'b0, GROUP);
        end
    end

    // Stage-1 pipeline register; holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            a_r        <= '0;
            bp_r       <= '0;
            c0_r       <= 1'b0;
            p_r        <= '0;
            g_r        <= '0;
            grp_r      <= '0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (accept_s) begin
                a_r   <= in_a;
                bp_r  <= bp_s;
                c0_r  <= c0_s;
                p_r   <= p_s;
                g_r   <= g_s;
                grp_r <= grp_s;
            end else begin
                a_r   <= a_r;
                bp_r  <= bp_r;
                c0_r  <= c0_r;
                p_r   <= p_r;
                g_r   <= g_r;
                grp_r <= grp_r;
            end
        end
    end

    // Second-level carry network across groups.
    always_comb begin
        gc_s[0] = c0_r;
        for (int k = 0; k < NG; k++) begin
            gc_s[k+1] = grp_r[k].g | (grp_r[k].p & gc_s[k]);
        end
    end

    generate
        for (genvar k = 0; k < NG; k++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .p     (p_r[k*GROUP +: GROUP]),
                .g     (g_r[k*GROUP +: GROUP]),
                .cin   (gc_s[k]),
                .sum   (sum_s[k*GROUP +: GROUP]),
                .grp_p (unused_grp_p_s[k]),
                .grp_g (unused_grp_g_s[k])
            );
        end
    endgenerate

    // Flags: overflow when both addends share a sign the result does not.
    always_comb begin
        cout_s = gc_s[NG];
        ovf_s  = ~(a_r[WIDTH-1] ^ bp_r[WIDTH-1]) & (sum_s[WIDTH-1] ^ a_r[WIDTH-1]);
        zero_s = ~|sum_s;
    end

    // Output register; result held until consumed, last value kept when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_zero_r  <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= 1'b1;
            out_sum_r   <= sum_s;
            out_cout_r  <= cout_s;
            out_ovf_r   <= ovf_s;
            out_zero_r  <= zero_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign out_ovf   = out_ovf_r;
    assign out_zero  = out_zero_r;

endmodule
